// File: rtl/program_counter_unit.sv
// program_counter_unit: 16-bit PC built from PCL/PCH byte registers.
// Loads from ADL/ADH, increments, flags PCL carry-out and full wrap.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   RDY                1 = advance, 0 = hold every register
//   LOAD_L, LOAD_H     load PCL from ADL_IN / PCH from ADH_IN
//   INC                add 1 to the (possibly loaded) 16-bit value
//   ADL_IN, ADH_IN     internal address bus low / high
//   PCL_OUT, PCH_OUT   registered PC bytes
//   PAGE_CROSS, WRAP   registered pulses describing the last update
module program_counter_unit #(
    parameter int              WIDTH    = 8,
    parameter logic [2*WIDTH-1:0] RESET_PC = 16'hFFFC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RDY,
    input  logic             LOAD_L,
    input  logic             LOAD_H,
    input  logic             INC,
    input  logic [WIDTH-1:0] ADL_IN,
    input  logic [WIDTH-1:0] ADH_IN,
    output logic [WIDTH-1:0] PCL_OUT,
    output logic [WIDTH-1:0] PCH_OUT,
    output logic             PAGE_CROSS,
    output logic             WRAP
);

    logic [WIDTH-1:0] pcl;
    logic [WIDTH-1:0] pch;
    logic             page_cross;
    logic             wrap;

    logic [WIDTH-1:0] base_l;
    logic [WIDTH-1:0] base_h;
    logic [WIDTH-1:0] next_l;
    logic [WIDTH-1:0] next_h;
    logic             carry_l;
    logic             carry_h;

    assign base_l = LOAD_L ? ADL_IN : pcl;
    assign base_h = LOAD_H ? ADH_IN : pch;

    // Carry ripples from the low byte into the high byte.
    assign {carry_l, next_l} = {1'b0, base_l} + {{WIDTH{1'b0}}, INC};
    assign {carry_h, next_h} = {1'b0, base_h} + {{WIDTH{1'b0}}, carry_l};

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcl        <= RESET_PC[WIDTH-1:0];
            pch        <= RESET_PC[2*WIDTH-1:WIDTH];
            page_cross <= 1'b0;
            wrap       <= 1'b0;
        end else if (RDY) begin
            pcl        <= next_l;
            pch        <= next_h;
            page_cross <= carry_l;
            wrap       <= carry_h;
        end
    end

    assign PCL_OUT    = pcl;
    assign PCH_OUT    = pch;
    assign PAGE_CROSS = page_cross;
    assign WRAP       = wrap;

endmodule

// File: tb/tb_program_counter_unit.sv
// tb_program_counter_unit: directed bench for program_counter_unit.
// Hand-computed PC and flag values after each clocked step.
module tb_program_counter_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RDY = 1'b0;
    logic       LOAD_L = 1'b0;
    logic       LOAD_H = 1'b0;
    logic       INC = 1'b0;
    logic [7:0] ADL_IN = 8'h00;
    logic [7:0] ADH_IN = 8'h00;
    logic [7:0] PCL_OUT;
    logic [7:0] PCH_OUT;
    logic       PAGE_CROSS;
    logic       WRAP;

    int checks = 0;
    int errors = 0;

    program_counter_unit #(
        .WIDTH(8),
        .RESET_PC(16'hFFFC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RDY(RDY),
        .LOAD_L(LOAD_L),
        .LOAD_H(LOAD_H),
        .INC(INC),
        .ADL_IN(ADL_IN),
        .ADH_IN(ADH_IN),
        .PCL_OUT(PCL_OUT),
        .PCH_OUT(PCH_OUT),
        .PAGE_CROSS(PAGE_CROSS),
        .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic step(
        input logic       rst,
        input logic       rdy,
        input logic       ll,
        input logic       lh,
        input logic       inc,
        input logic [7:0] adl,
        input logic [7:0] adh
    );
        RST    = rst;
        RDY    = rdy;
        LOAD_L = ll;
        LOAD_H = lh;
        INC    = inc;
        ADL_IN = adl;
        ADH_IN = adh;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [15:0] pc_exp,
        input logic        pcx_exp,
        input logic        wr_exp
    );
        logic [15:0] pc_obs;
        pc_obs = {PCH_OUT, PCL_OUT};
        checks++;
        assert (pc_obs === pc_exp) else begin
            errors++;
            $error("FAIL %s pc obs=%h exp=%h", tag, pc_obs, pc_exp);
        end
        checks++;
        assert (PAGE_CROSS === pcx_exp) else begin
            errors++;
            $error("FAIL %s page_cross obs=%b exp=%b",
                   tag, PAGE_CROSS, pcx_exp);
        end
        checks++;
        assert (WRAP === wr_exp) else begin
            errors++;
            $error("FAIL %s wrap obs=%b exp=%b", tag, WRAP, wr_exp);
        end
    endtask

    initial begin
        #2;
        // reset for two cycles, then release idle
        step(1, 1, 0, 0, 0, 8'h00, 8'h00);
        chk("rst0", 16'hFFFC, 0, 0);
        step(1, 1, 0, 0, 0, 8'h00, 8'h00);
        chk("rst1", 16'hFFFC, 0, 0);
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        chk("idle0", 16'hFFFC, 0, 0);
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        chk("idle1", 16'hFFFC, 0, 0);

        // sequential increment across a page
        step(0, 1, 1, 1, 0, 8'hFE, 8'h12);
        chk("ld12FE", 16'h12FE, 0, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("inc12FF", 16'h12FF, 0, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("inc1300", 16'h1300, 1, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("inc1301", 16'h1301, 0, 0);

        // full wrap
        step(0, 1, 1, 1, 0, 8'hFF, 8'hFF);
        chk("ldFFFF", 16'hFFFF, 0, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("wrap", 16'h0000, 1, 1);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("postwrap", 16'h0001, 0, 0);

        // split loads from reset value, then combined load+inc
        step(1, 1, 0, 0, 0, 8'h00, 8'h00);
        chk("rst2", 16'hFFFC, 0, 0);
        step(0, 1, 1, 0, 0, 8'h34, 8'hAA);
        chk("ldl", 16'hFF34, 0, 0);
        step(0, 1, 0, 1, 0, 8'h55, 8'hC0);
        chk("ldh", 16'hC034, 0, 0);
        step(0, 1, 1, 1, 1, 8'hFF, 8'h20);
        chk("ldinc", 16'h2100, 1, 0);

        // stall with flags set
        step(0, 1, 1, 1, 0, 8'hFE, 8'h10);
        chk("ld10FE", 16'h10FE, 0, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("inc10FF", 16'h10FF, 0, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("inc1100", 16'h1100, 1, 0);
        step(0, 0, 1, 0, 1, 8'h55, 8'h00);
        chk("stall0", 16'h1100, 1, 0);
        step(0, 0, 1, 0, 1, 8'h55, 8'h00);
        chk("stall1", 16'h1100, 1, 0);
        step(0, 0, 1, 0, 1, 8'h55, 8'h00);
        chk("stall2", 16'h1100, 1, 0);
        step(0, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("resume", 16'h1101, 0, 0);

        // stall holding a wrap pulse
        step(0, 1, 1, 1, 1, 8'hFF, 8'hFF);
        chk("ldwrap", 16'h0000, 1, 1);
        step(0, 0, 0, 0, 1, 8'h00, 8'h00);
        chk("stallwrap", 16'h0000, 1, 1);

        // reset beats an increment and a stall
        step(0, 1, 1, 1, 0, 8'hFF, 8'h12);
        chk("ld12FF", 16'h12FF, 0, 0);
        step(1, 1, 0, 0, 1, 8'h00, 8'h00);
        chk("rstinc", 16'hFFFC, 0, 0);
        step(0, 1, 1, 1, 0, 8'h34, 8'h12);
        chk("ld1234", 16'h1234, 0, 0);
        step(1, 0, 1, 1, 1, 8'h00, 8'h00);
        chk("rststall", 16'hFFFC, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
